// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU for the factorial CPU datapath.
// Single-cycle ops complete one clock after start. MUL is an iterative shift-add multiplier
// that runs for WIDTH clocks. Results and flags are registered and held between completions.
module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             ovf_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpInc = 3'b101;
    localparam logic [2:0] OpDec = 3'b110;
    localparam logic [2:0] OpMul = 3'b111;

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;

    logic [WIDTH:0]       alu_ext;
    logic [2*WIDTH-1:0]   acc_sum;

    // Single-cycle datapath: bit WIDTH of the extended result is carry (add) or borrow (sub).
    always_comb begin
        alu_ext = '0;
        case (op_i)
            OpAdd:   alu_ext = {1'b0, a_i} + {1'b0, b_i};
            OpSub:   alu_ext = {1'b0, a_i} - {1'b0, b_i};
            OpAnd:   alu_ext = {1'b0, a_i & b_i};
            OpOr:    alu_ext = {1'b0, a_i | b_i};
            OpXor:   alu_ext = {1'b0, a_i ^ b_i};
            OpInc:   alu_ext = {1'b0, a_i} + (WIDTH+1)'(1);
            OpDec:   alu_ext = {1'b0, a_i} - (WIDTH+1)'(1);
            default: alu_ext = '0;
        endcase
    end

    // Next-state logic for the FSM, the multiplier and the result registers.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (op_i == OpMul) begin
                        mcand_d  = {{WIDTH{1'b0}}, a_i};
                        mplier_d = b_i;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = StMul;
                    end else begin
                        result_d = alu_ext[WIDTH-1:0];
                        zero_d   = (alu_ext[WIDTH-1:0] == '0);
                        carry_d  = alu_ext[WIDTH];
                        ovf_d    = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            StMul: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CntW'(1);
                // Last iteration: commit the product straight from the adder output.
                if (count_q == CntW'(WIDTH - 1)) begin
                    result_d = acc_sum[WIDTH-1:0];
                    zero_d   = (acc_sum[WIDTH-1:0] == '0);
                    carry_d  = 1'b0;
                    ovf_d    = |acc_sum[2*WIDTH-1:WIDTH];
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any MUL in flight and clears all outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy_o   = (state_q == StMul);
    assign done_o   = done_q;
    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign carry_o  = carry_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: directed vectors, expected responses queued at issue time and
// checked by an independent monitor whenever done is seen.
module tb_seq_alu;

    localparam int unsigned W = 8;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpInc = 3'b101;
    localparam logic [2:0] OpDec = 3'b110;
    localparam logic [2:0] OpMul = 3'b111;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         start = 1'b0;
    logic         busy, done, zero, carry, ovf;
    logic [W-1:0] result;

    typedef struct {
        string        nm;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         o;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .a_i      (a),
        .b_i      (b),
        .op_i     (op),
        .start_i  (start),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result),
        .zero_o   (zero),
        .carry_o  (carry),
        .ovf_o    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse; also guards done/busy exclusivity.
    always @(negedge clk) begin
        if (!reset) begin
            if (done && busy) begin
                n_run++;
                n_fail++;
                $display("FAIL done_busy_overlap: done=%b busy=%b, expected not both", done, busy);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL unexpected_done: result=%0h, expected no done", result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.nm, "_result"}, int'(result), int'(e.res));
                    check({e.nm, "_zero"},   int'(zero),   int'(e.z));
                    check({e.nm, "_carry"},  int'(carry),  int'(e.c));
                    check({e.nm, "_ovf"},    int'(ovf),    int'(e.o));
                end
            end
        end
    end

    // Presents one start cycle; called and returns at posedge+1.
    task automatic issue(input string nm, input logic [2:0] o, input logic [W-1:0] va,
                         input logic [W-1:0] vb, input logic [W-1:0] er, input logic ez,
                         input logic ec, input logic eo);
        exp_t e;
        e.nm = nm; e.res = er; e.z = ez; e.c = ec; e.o = eo;
        sb.push_back(e);
        op = o; a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Measures edges to done after the sampling edge and busy cycles, then checks done drops.
    task automatic timing(input string nm, input int exp_lat, input int exp_busy);
        int lat = 0;
        int bc  = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, lat, exp_lat);
        check({nm, "_busy_cycles"}, bc, exp_busy);
        @(posedge clk); #1;
        check({nm, "_done_drop"}, int'(done), 0);
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!done && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check({nm, "_done_seen"}, int'(done), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy",   int'(busy),   0);
        check("reset_done",   int'(done),   0);
        check("reset_result", int'(result), 0);
        check("reset_flags",  int'({zero, carry, ovf}), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        issue("add_ff_01", OpAdd, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
        timing("add", 0, 0);
        issue("sub_03_05", OpSub, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b0);
        issue("dec_00",    OpDec, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
        issue("inc_7f",    OpInc, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0);
        issue("add_12_34", OpAdd, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);
        issue("sub_05_05", OpSub, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0);
        issue("dec_01",    OpDec, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        issue("inc_ff",    OpInc, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        issue("and_f0_3c", OpAnd, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
        issue("or_f0_0f",  OpOr,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0);
        issue("xor_aa_aa", OpXor, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        issue("mul_05_06", OpMul, 8'h05, 8'h06, 8'h1E, 1'b0, 1'b0, 1'b0);
        timing("mul", W, W);
        issue("mul_10_10", OpMul, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1);
        timing("mul_ovf", W, W);

        // start while busy must be ignored; operand changes must not disturb the product
        issue("mul_ign", OpMul, 8'h05, 8'h06, 8'h1E, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        op = OpAdd; a = 8'hFF; b = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("mul_ign");
        repeat (12) @(posedge clk);
        #1;

        // reset in the middle of a MUL: outputs clear at once, no done afterwards
        issue("mul_rst", OpMul, 8'h07, 8'h09, 8'h3F, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_busy",   int'(busy),   0);
        check("rst_done",   int'(done),   0);
        check("rst_result", int'(result), 0);
        check("rst_flags",  int'({zero, carry, ovf}), 0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("rst_no_done_busy", int'(busy), 0);

        // back-to-back single-cycle ops, second start in the done cycle of the first
        issue("b2b_xor", OpXor, 8'h0F, 8'hFF, 8'hF0, 1'b0, 1'b0, 1'b0);
        issue("b2b_or",  OpOr,  8'h00, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;

        // factorial chain: result fed back as operand a
        issue("fact_2", OpMul, result, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0);
        wait_done("fact_2");
        issue("fact_3", OpMul, result, 8'h03, 8'h06, 1'b0, 1'b0, 1'b0);
        wait_done("fact_3");
        issue("fact_4", OpMul, result, 8'h04, 8'h18, 1'b0, 1'b0, 1'b0);
        wait_done("fact_4");
        issue("fact_5", OpMul, result, 8'h05, 8'h78, 1'b0, 1'b0, 1'b0);
        wait_done("fact_5");
        issue("fact_6", OpMul, result, 8'h06, 8'hD0, 1'b0, 1'b0, 1'b1);
        wait_done("fact_6");

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
